// File: rtl/lift_ctrl_nflr_pkg.sv
// Shared definitions for the N-floor lift controller.
//   state_e     : controller FSM encoding (door open / idle / moving)
//   timer_width : width of the shared dwell/travel down-counter
//   params_ok   : legal parameter range check used by the top level
package lift_ctrl_nflr_pkg;

  typedef enum logic [1:0] {
    StOpen = 2'd0,
    StIdle = 2'd1,
    StMove = 2'd2
  } state_e;

  // Counter must hold the larger of the two reload values.
  function automatic int unsigned timer_width(input int unsigned door_cyc,
                                              input int unsigned travel_cyc);
    int unsigned max_cyc;
    max_cyc = (door_cyc > travel_cyc) ? door_cyc : travel_cyc;
    return $clog2(max_cyc + 1);
  endfunction

  function automatic bit params_ok(input int unsigned num_flr,
                                   input int unsigned door_cyc,
                                   input int unsigned travel_cyc);
    return (num_flr >= 2) && (door_cyc >= 1) && (travel_cyc >= 1);
  endfunction

endpackage

// File: rtl/lift_ctrl_nflr_if.sv
// Call-button / actuator bundle of the lift controller.
//   master : call-button front end (drives requests and door obstruction)
//   slave  : lift controller (drives floor, door, motor, direction, pending masks)
interface lift_ctrl_nflr_if #(
  parameter int unsigned NUM_FLR = 8
) ();
  localparam int unsigned FlrW = $clog2(NUM_FLR);

  logic [NUM_FLR-1:0] car_req;
  logic [NUM_FLR-1:0] hall_up_req;
  logic [NUM_FLR-1:0] hall_dn_req;
  logic               door_obst;
  logic [FlrW-1:0]    cur_flr;
  logic               door;
  logic               mov_up;
  logic               mov_dn;
  logic               dir_up;
  logic [NUM_FLR-1:0] pend_car;
  logic [NUM_FLR-1:0] pend_up;
  logic [NUM_FLR-1:0] pend_dn;

  modport master (
    output car_req, hall_up_req, hall_dn_req, door_obst,
    input  cur_flr, door, mov_up, mov_dn, dir_up, pend_car, pend_up, pend_dn
  );

  modport slave (
    input  car_req, hall_up_req, hall_dn_req, door_obst,
    output cur_flr, door, mov_up, mov_dn, dir_up, pend_car, pend_up, pend_dn
  );

endinterface

// File: rtl/lift_ctrl_nflr_req_reg.sv
// Pending-call register for one request class (car, hall up or hall down).
//   clk, reset : clock, synchronous active-high reset
//   req        : raw call buttons, one per floor; bits outside VALID are dropped
//   clr        : served-call clear mask; clear wins over a same-cycle set
//   flr        : floor the reductions are evaluated for
//   pend       : latched pending calls
//   above      : some pending call strictly above flr
//   below      : some pending call strictly below flr
//   at         : pending call at flr
//   req_at     : masked raw request at flr this cycle
module lift_ctrl_nflr_req_reg #(
  parameter int unsigned        NUM_FLR = 8,
  parameter logic [NUM_FLR-1:0] VALID   = '1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_FLR-1:0]         req,
  input  logic [NUM_FLR-1:0]         clr,
  input  logic [$clog2(NUM_FLR)-1:0] flr,
  output logic [NUM_FLR-1:0]         pend,
  output logic                       above,
  output logic                       below,
  output logic                       at,
  output logic                       req_at
);
  localparam int unsigned FlrW = $clog2(NUM_FLR);

  logic [NUM_FLR-1:0] req_m;
  logic [NUM_FLR-1:0] pend_d;
  logic [NUM_FLR-1:0] pend_q;

  assign req_m  = req & VALID;
  assign pend_d = (pend_q | req_m) & ~clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLR; i++) begin
      if (FlrW'(i) > flr) above = above | pend_q[i];
      if (FlrW'(i) < flr) below = below | pend_q[i];
    end
  end

  assign at     = pend_q[flr];
  assign req_at = req_m[flr];
  assign pend   = pend_q;

endmodule

// File: rtl/lift_ctrl_nflr.sv
// N-floor collective-selective lift controller.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset; also homes the car to floor 0 mid-move
//   bus   : slave side of lift_ctrl_nflr_if (call buttons in; floor, door, motor,
//           direction and pending call masks out)
// One down-counter is shared between door dwell (StOpen) and per-floor travel (StMove).
module lift_ctrl_nflr
  import lift_ctrl_nflr_pkg::*;
#(
  parameter int unsigned NUM_FLR    = 8,
  parameter int unsigned DOOR_CYC   = 16,
  parameter int unsigned TRAVEL_CYC = 32
) (
  input logic             clk,
  input logic             reset,
  lift_ctrl_nflr_if.slave bus
);
  localparam int unsigned       FlrW     = $clog2(NUM_FLR);
  localparam int unsigned       TmrW     = timer_width(DOOR_CYC, TRAVEL_CYC);
  localparam logic [TmrW-1:0]   DoorLd   = TmrW'(DOOR_CYC);
  localparam logic [TmrW-1:0]   TravelLd = TmrW'(TRAVEL_CYC);
  localparam logic [FlrW-1:0]   TopFlr   = FlrW'(NUM_FLR - 1);
  localparam logic [NUM_FLR-1:0] UpValid = {1'b0, {(NUM_FLR-1){1'b1}}};
  localparam logic [NUM_FLR-1:0] DnValid = {{(NUM_FLR-1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [FlrW-1:0] flr_q, flr_d;
  logic            dir_up_q, dir_up_d;

  logic [FlrW-1:0] step_flr;
  logic [FlrW-1:0] eval_flr;

  logic [NUM_FLR-1:0] clr_car, clr_up, clr_dn;
  logic car_above, car_below, car_at, car_req_at;
  logic up_above, up_below, up_at, up_req_at;
  logic dn_above, dn_below, dn_at, dn_req_at;
  logic above_any, below_any, ahead, behind, here, req_here;

  // Neighbouring floor in the travel direction, pinned at the shaft ends.
  always_comb begin
    step_flr = flr_q;
    if (dir_up_q) begin
      if (flr_q != TopFlr) step_flr = flr_q + FlrW'(1);
    end else begin
      if (flr_q != '0) step_flr = flr_q - FlrW'(1);
    end
  end

  // While moving, decisions are taken for the floor about to be reached so the
  // stop/continue choice lands on the same edge as the floor change.
  assign eval_flr = (state_q == StMove) ? step_flr : flr_q;

  lift_ctrl_nflr_req_reg #(
    .NUM_FLR (NUM_FLR),
    .VALID   ('1)
  ) u_car (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.car_req),
    .clr    (clr_car),
    .flr    (eval_flr),
    .pend   (bus.pend_car),
    .above  (car_above),
    .below  (car_below),
    .at     (car_at),
    .req_at (car_req_at)
  );

  lift_ctrl_nflr_req_reg #(
    .NUM_FLR (NUM_FLR),
    .VALID   (UpValid)
  ) u_up (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.hall_up_req),
    .clr    (clr_up),
    .flr    (eval_flr),
    .pend   (bus.pend_up),
    .above  (up_above),
    .below  (up_below),
    .at     (up_at),
    .req_at (up_req_at)
  );

  lift_ctrl_nflr_req_reg #(
    .NUM_FLR (NUM_FLR),
    .VALID   (DnValid)
  ) u_dn (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.hall_dn_req),
    .clr    (clr_dn),
    .flr    (eval_flr),
    .pend   (bus.pend_dn),
    .above  (dn_above),
    .below  (dn_below),
    .at     (dn_at),
    .req_at (dn_req_at)
  );

  assign above_any = car_above | up_above | dn_above;
  assign below_any = car_below | up_below | dn_below;
  assign ahead     = dir_up_q ? above_any : below_any;
  assign behind    = dir_up_q ? below_any : above_any;
  // A hall call against the travel direction is served only when nothing lies ahead.
  assign here      = car_at | (dir_up_q ? up_at : dn_at) | (~ahead & (up_at | dn_at));
  assign req_here  = car_req_at | (dir_up_q ? up_req_at : dn_req_at) |
                     (~ahead & (up_req_at | dn_req_at));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StOpen;
      tmr_q    <= DoorLd;
      flr_q    <= '0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      flr_q    <= flr_d;
      dir_up_q <= dir_up_d;
    end
  end

  // Out-of-range parameters are reported while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (params_ok(NUM_FLR, DOOR_CYC, TRAVEL_CYC))
        else $error("lift_ctrl_nflr: need NUM_FLR>=2, DOOR_CYC>=1, TRAVEL_CYC>=1");
    end
  end

  // Next-state logic. The counter expiring at 1 gives exactly DOOR_CYC / TRAVEL_CYC
  // cycles per reload.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    flr_d    = flr_q;
    dir_up_d = dir_up_q;
    unique case (state_q)
      StOpen: begin
        if (bus.door_obst || req_here) begin
          tmr_d = DoorLd;
        end else if (tmr_q > TmrW'(1)) begin
          tmr_d = tmr_q - TmrW'(1);
        end else begin
          state_d = StIdle;
          tmr_d   = '0;
        end
      end
      StIdle: begin
        if (here) begin
          state_d = StOpen;
          tmr_d   = DoorLd;
        end else if (ahead) begin
          state_d = StMove;
          tmr_d   = TravelLd;
        end else if (behind) begin
          dir_up_d = ~dir_up_q;
          state_d  = StMove;
          tmr_d    = TravelLd;
        end
      end
      StMove: begin
        if (tmr_q > TmrW'(1)) begin
          tmr_d = tmr_q - TmrW'(1);
        end else begin
          flr_d = step_flr;
          if (here || !ahead) begin
            state_d = StOpen;
            tmr_d   = DoorLd;
          end else begin
            tmr_d = TravelLd;
          end
        end
      end
      default: begin
        state_d = StOpen;
        tmr_d   = DoorLd;
      end
    endcase
  end

  // Calls at the floor are cleared on every edge that leaves the door open,
  // including the arrival / door-opening edge itself.
  always_comb begin
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    if (state_d == StOpen) begin
      clr_car[eval_flr] = 1'b1;
      if (dir_up_q || !ahead)  clr_up[eval_flr] = 1'b1;
      if (!dir_up_q || !ahead) clr_dn[eval_flr] = 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    bus.cur_flr = flr_q;
    bus.door    = (state_q == StOpen);
    bus.mov_up  = (state_q == StMove) && dir_up_q;
    bus.mov_dn  = (state_q == StMove) && !dir_up_q;
    bus.dir_up  = dir_up_q;
  end

endmodule

// File: tb/tb_lift_ctrl_nflr.sv
// Directed bench for lift_ctrl_nflr with NUM_FLR=4, DOOR_CYC=4, TRAVEL_CYC=3.
module tb_lift_ctrl_nflr;
  localparam int unsigned NFlr = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  lift_ctrl_nflr_if #(.NUM_FLR(NFlr)) bus ();

  lift_ctrl_nflr #(
    .NUM_FLR    (NFlr),
    .DOOR_CYC   (4),
    .TRAVEL_CYC (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Motor directions exclusive, door never open while moving.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_chk++;
      assert (!(bus.mov_up && bus.mov_dn) && !(bus.door && (bus.mov_up || bus.mov_dn)))
      else begin
        n_fail++;
        $error("FAIL excl: observed door=%b up=%b dn=%b, expected at most one set",
               bus.door, bus.mov_up, bus.mov_dn);
      end
    end
  end

  initial begin
    #20000;
    $error("FAIL watchdog: observed no finish by t=20000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.car_req     = '0;
    bus.hall_up_req = '0;
    bus.hall_dn_req = '0;
    bus.door_obst   = 1'b0;
    tick(2);
    chk("rst_flr", 32'(bus.cur_flr), 0);
    chk("rst_door", 32'(bus.door), 1);
    chk("rst_mov", {bus.mov_up, bus.mov_dn}, 0);
    chk("rst_dir", 32'(bus.dir_up), 1);
    chk("rst_pend", {bus.pend_car, bus.pend_up, bus.pend_dn}, 0);

    // 1: door dwell after reset release
    reset = 1'b0;
    tick(3);
    chk("t1_door_held", 32'(bus.door), 1);
    tick(1);
    chk("t1_door_closed", 32'(bus.door), 0);
    chk("t1_flr", 32'(bus.cur_flr), 0);
    tick(2);
    chk("t1_idle", {bus.door, bus.mov_up, bus.mov_dn}, 0);
    chk("t1_pend", {bus.pend_car, bus.pend_up, bus.pend_dn}, 0);

    // 2: car call to floor 3
    bus.car_req = 4'b1000;
    tick(1);
    bus.car_req = '0;
    chk("t2_latched", 32'(bus.pend_car), 32'h8);
    chk("t2_not_yet", 32'(bus.mov_up), 0);
    tick(1);
    chk("t2_mov_up", {bus.mov_up, bus.mov_dn}, 2'b10);
    chk("t2_flr0", 32'(bus.cur_flr), 0);
    tick(3);
    chk("t2_flr1", 32'(bus.cur_flr), 1);
    tick(3);
    chk("t2_flr2", 32'(bus.cur_flr), 2);
    tick(2);
    chk("t2_still2", {30'(bus.cur_flr), bus.mov_up, bus.door}, {30'd2, 2'b10});
    tick(1);
    chk("t2_flr3", 32'(bus.cur_flr), 3);
    chk("t2_arrive", {bus.door, bus.mov_up}, 2'b10);
    chk("t2_pend_clr", 32'(bus.pend_car), 0);
    tick(4);
    chk("t2_closed", 32'(bus.door), 0);

    // 3: down to floor 2, obstruction holds the door
    bus.car_req = 4'b0100;
    tick(1);
    bus.car_req = '0;
    tick(1);
    chk("t3_dir_flip", 32'(bus.dir_up), 0);
    chk("t3_mov_dn", {bus.mov_up, bus.mov_dn}, 2'b01);
    tick(3);
    chk("t3_at2", {30'(bus.cur_flr), bus.door, bus.mov_dn}, {30'd2, 2'b10});
    chk("t3_pend_clr", 32'(bus.pend_car), 0);
    bus.door_obst = 1'b1;
    tick(10);
    chk("t3_obst_held", 32'(bus.door), 1);
    bus.door_obst = 1'b0;
    tick(3);
    chk("t3_dwell", 32'(bus.door), 1);
    tick(1);
    chk("t3_closed", 32'(bus.door), 0);

    // 4a: up hall call at 2 on the way to 3 is served first
    do_reset();
    tick(4);
    chk("t4a_idle", {bus.door, bus.mov_up, 30'(bus.cur_flr)}, 0);
    bus.car_req = 4'b1000;
    tick(1);
    bus.car_req = '0;
    tick(1);
    chk("t4a_mov", 32'(bus.mov_up), 1);
    bus.hall_up_req = 4'b0100;
    tick(1);
    bus.hall_up_req = '0;
    chk("t4a_up_latched", 32'(bus.pend_up), 32'h4);
    tick(5);
    chk("t4a_stop2", {30'(bus.cur_flr), bus.door, bus.mov_up}, {30'd2, 2'b10});
    chk("t4a_pend", {bus.pend_car, bus.pend_up}, {4'b1000, 4'b0000});
    tick(4);
    chk("t4a_closed", 32'(bus.door), 0);
    tick(1);
    chk("t4a_resume", 32'(bus.mov_up), 1);
    tick(3);
    chk("t4a_at3", {30'(bus.cur_flr), bus.door, bus.mov_up}, {30'd3, 2'b10});
    chk("t4a_car_clr", 32'(bus.pend_car), 0);

    // 4b: down hall call at 2 is passed, served after reversing at 3
    do_reset();
    tick(4);
    bus.car_req = 4'b1000;
    tick(1);
    bus.car_req = '0;
    tick(1);
    bus.hall_dn_req = 4'b0100;
    tick(1);
    bus.hall_dn_req = '0;
    chk("t4b_dn_latched", 32'(bus.pend_dn), 32'h4);
    tick(5);
    chk("t4b_pass2", {30'(bus.cur_flr), bus.door, bus.mov_up}, {30'd2, 2'b01});
    tick(3);
    chk("t4b_at3", {30'(bus.cur_flr), bus.door, bus.dir_up}, {30'd3, 2'b11});
    chk("t4b_pend3", {bus.pend_car, bus.pend_dn}, {4'b0000, 4'b0100});
    tick(4);
    chk("t4b_closed", 32'(bus.door), 0);
    tick(1);
    chk("t4b_reverse", {bus.dir_up, bus.mov_up, bus.mov_dn}, 3'b001);
    tick(3);
    chk("t4b_at2", {30'(bus.cur_flr), bus.door, bus.mov_dn}, {30'd2, 2'b10});
    chk("t4b_dn_clr", 32'(bus.pend_dn), 0);

    // 5: end-floor hall calls that do not exist are dropped
    do_reset();
    tick(4);
    bus.hall_dn_req = 4'b0001;
    bus.hall_up_req = 4'b1000;
    tick(1);
    chk("t5_masked", {bus.pend_up, bus.pend_dn}, 0);
    tick(3);
    chk("t5_no_motion", {bus.door, bus.mov_up, bus.mov_dn, 29'(bus.cur_flr)}, 0);
    bus.hall_dn_req = '0;
    bus.hall_up_req = '0;

    // 6: reset mid-move homes the car
    bus.car_req = 4'b1000;
    tick(1);
    bus.car_req = '0;
    tick(1);
    chk("t6_mov", 32'(bus.mov_up), 1);
    tick(6);
    chk("t6_at2", {30'(bus.cur_flr), bus.mov_up, bus.door}, {30'd2, 2'b10});
    reset = 1'b1;
    tick(1);
    chk("t6_home", {30'(bus.cur_flr), bus.door, bus.dir_up}, {30'd0, 2'b11});
    chk("t6_mov_off", {bus.mov_up, bus.mov_dn}, 0);
    chk("t6_pend", {bus.pend_car, bus.pend_up, bus.pend_dn}, 0);
    reset = 1'b0;
    tick(6);
    chk("t6_stays", {bus.door, bus.mov_up, bus.mov_dn, 29'(bus.cur_flr)}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
